// File: rtl/fg_prog_sequencer_pkg.sv
// Shared types and constants for the floating-gate programming sequencer.
package fg_prog_pkg;

  localparam int DRAIN_BITS_DEF = 5;
  localparam int GATE_BITS_DEF  = 2;
  localparam int PLEN_W_DEF     = 16;
  localparam int PCNT_W_DEF     = 8;

  // Decoders are active-low: all ones selects no line at all.
  localparam logic [DRAIN_BITS_DEF-1:0] DRAIN_IDLE_B = '1;
  localparam logic [GATE_BITS_DEF-1:0]  GATE_IDLE_B  = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_RECOVER,
    ST_FINISH
  } state_t;

  // Latched command; pcnt doubles as the remaining-pulse counter.
  typedef struct packed {
    logic [DRAIN_BITS_DEF-1:0] drain;
    logic [GATE_BITS_DEF-1:0]  gate;
    logic [PLEN_W_DEF-1:0]     plen;
    logic [PCNT_W_DEF-1:0]     pcnt;
  } cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fg_prog_sequencer_if.sv
// Host-side command/status bundle between the register block and the sequencer.
interface fg_prog_sequencer_if #(
  parameter int DRAIN_BITS = 5,
  parameter int GATE_BITS  = 2,
  parameter int PLEN_W     = 16,
  parameter int PCNT_W     = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DRAIN_BITS-1:0] cmd_drain;
  logic [GATE_BITS-1:0]  cmd_gate;
  logic [PLEN_W-1:0]     cmd_plen;
  logic [PCNT_W-1:0]     cmd_pcnt;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output cmd_valid, cmd_drain, cmd_gate, cmd_plen, cmd_pcnt, abort,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_drain, cmd_gate, cmd_plen, cmd_pcnt, abort,
    output cmd_ready, busy, done, err
  );
endinterface

// File: rtl/fg_prog_sequencer_timer.sv
// Loadable down-counter that parks at zero; one instance times every
// fixed-length phase of the sequencer.
module fg_prog_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; the count stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/fg_prog_sequencer.sv
// Command-driven programming sequencer: selects one drain line and one gate
// column, then applies a train of timed injection pulses. Every island control
// output is a flop computed from the next state, so nothing glitches and reset
// forces the safe run-mode values asynchronously.
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter int DRAIN_BITS = DRAIN_BITS_DEF,
  parameter int GATE_BITS  = GATE_BITS_DEF,
  parameter int NUM_DRAIN  = 20,
  parameter int NUM_GATE   = 4,
  parameter int PLEN_W     = PLEN_W_DEF,
  parameter int PCNT_W     = PCNT_W_DEF,
  parameter int SETTLE_CYC = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fg_prog_sequencer_if.slave    cmd,
  output logic                  prog,
  output logic                  run,
  output logic                  vgsel,
  output logic                  drain_en,
  output logic [DRAIN_BITS-1:0] drain_b,
  output logic                  gate_en,
  output logic [GATE_BITS-1:0]  gate_b
);

  localparam int CNT_W = max_int(PLEN_W, $clog2(max_int(SETTLE_CYC, GAP_CYC) + 1));
  localparam logic [DRAIN_BITS:0] NUM_DRAIN_L = (DRAIN_BITS + 1)'(NUM_DRAIN);
  localparam logic [GATE_BITS:0]  NUM_GATE_L  = (GATE_BITS + 1)'(NUM_GATE);
  // Timer holds "cycles remaining minus one" so zero marks the final cycle.
  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_VAL    = CNT_W'(GAP_CYC - 1);

  state_t              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic                err_flag_q, err_flag_d;
  logic                tmr_load, tmr_zero;
  logic [CNT_W-1:0]    tmr_val, pulse_val;
  logic                addr_bad, in_window;

  logic                  prog_q, prog_d, run_q, run_d, vgsel_q, vgsel_d;
  logic                  drain_en_q, drain_en_d, gate_en_q, gate_en_d;
  logic [DRAIN_BITS-1:0] drain_b_q, drain_b_d;
  logic [GATE_BITS-1:0]  gate_b_q, gate_b_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  cmd_ready_q, cmd_ready_d;

  assign addr_bad  = ({1'b0, cmd.cmd_drain} >= NUM_DRAIN_L) ||
                     ({1'b0, cmd.cmd_gate}  >= NUM_GATE_L);
  // A zero pulse length still produces a one-cycle pulse.
  assign pulse_val = (cmd_q.plen == '0) ? '0 : (CNT_W'(cmd_q.plen) - CNT_W'(1));
  assign in_window = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_GAP);

  fg_prog_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state logic: command capture, phase sequencing, pulse bookkeeping.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    err_flag_d = err_flag_q;
    tmr_load   = 1'b0;
    tmr_val    = SETTLE_VAL;
    if (in_window && cmd.abort) begin
      // Abort only while the programming rails are up; recovery is always full length.
      state_d    = ST_RECOVER;
      err_flag_d = 1'b1;
      tmr_load   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            cmd_d.drain = cmd.cmd_drain;
            cmd_d.gate  = cmd.cmd_gate;
            cmd_d.plen  = cmd.cmd_plen;
            cmd_d.pcnt  = cmd.cmd_pcnt;
            err_flag_d  = addr_bad;
            state_d     = addr_bad ? ST_FINISH : ST_SETUP;
            tmr_load    = 1'b1;
          end
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (cmd_q.pcnt == '0) begin
              state_d = ST_RECOVER;
            end else begin
              state_d = ST_PULSE;
              tmr_val = pulse_val;
            end
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            tmr_load   = 1'b1;
            cmd_d.pcnt = cmd_q.pcnt - PCNT_W'(1);
            if (cmd_q.pcnt > PCNT_W'(1)) begin
              state_d = ST_GAP;
              tmr_val = GAP_VAL;
            end else begin
              state_d = ST_RECOVER;
            end
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            state_d  = ST_PULSE;
            tmr_load = 1'b1;
            tmr_val  = pulse_val;
          end
        end
        ST_RECOVER: begin
          if (tmr_zero) begin
            state_d = ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    prog_d      = 1'b0;
    run_d       = 1'b1;
    vgsel_d     = 1'b0;
    drain_en_d  = 1'b0;
    gate_en_d   = 1'b0;
    drain_b_d   = DRAIN_IDLE_B;
    gate_b_d    = GATE_IDLE_B;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cmd_ready_d = 1'b0;
    unique case (state_d)
      ST_IDLE: begin
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
      ST_SETUP, ST_GAP, ST_PULSE: begin
        run_d      = 1'b0;
        prog_d     = 1'b1;
        vgsel_d    = 1'b1;
        drain_b_d  = ~cmd_d.drain;
        gate_b_d   = ~cmd_d.gate;
        drain_en_d = (state_d == ST_PULSE);
        gate_en_d  = (state_d == ST_PULSE);
      end
      ST_RECOVER: begin
        run_d = 1'b0;
      end
      ST_FINISH: begin
        done_d = 1'b1;
        err_d  = err_flag_d;
      end
      default: ;
    endcase
  end

  // State, command and output registers with safe run-mode reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      err_flag_q  <= 1'b0;
      prog_q      <= 1'b0;
      run_q       <= 1'b1;
      vgsel_q     <= 1'b0;
      drain_en_q  <= 1'b0;
      gate_en_q   <= 1'b0;
      drain_b_q   <= DRAIN_IDLE_B;
      gate_b_q    <= GATE_IDLE_B;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      err_flag_q  <= err_flag_d;
      prog_q      <= prog_d;
      run_q       <= run_d;
      vgsel_q     <= vgsel_d;
      drain_en_q  <= drain_en_d;
      gate_en_q   <= gate_en_d;
      drain_b_q   <= drain_b_d;
      gate_b_q    <= gate_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign prog          = prog_q;
  assign run           = run_q;
  assign vgsel         = vgsel_q;
  assign drain_en      = drain_en_q;
  assign gate_en       = gate_en_q;
  assign drain_b       = drain_b_q;
  assign gate_b        = gate_b_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.cmd_ready = cmd_ready_q;

endmodule
